tlb_unit: RTL and testbench

//  Joint TLB downstream of CP0_reg: holds TLBNUM entries; executes tlbwi/tlbr/tlbp from CP0 and

---
 rtl/tlb_unit_pkg.sv | 65 ++++++
 rtl/tlb_match.sv | 51 +++++
 rtl/tlb_unit.sv | 196 +++++++++++++++++++
 tb/tb_tlb_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tlb_unit_pkg.sv
// Shared TLB definitions: entry layout, address region codes and the translation helper.
// Used by tlb_unit and tlb_match; TLB_MULTIHIT_EN is handled in those files.
package tlb_unit_pkg;

  localparam int          ENTRY_W    = 78;
  localparam logic [1:0]  KSEG01     = 2'b10;
  localparam logic [2:0]  KSEG1      = 3'b101;
  localparam logic [2:0]  C_UNCACHED = 3'd2;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
  } tlb_tag_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        refill;
    logic        inval;
    logic        mod;
    logic        uncached;
  } xlate_t;

  // Unmapped kseg0/kseg1 bypass the TLB; mapped misses report refill with paddr 0.
  function automatic xlate_t xlate(input tlb_entry_t e, input logic hit,
                                   input logic [31:0] va, input logic store);
    xlate_t      r;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r   = '0;
    pfn = va[12] ? e.pfn1 : e.pfn0;
    c   = va[12] ? e.c1   : e.c0;
    d   = va[12] ? e.d1   : e.d0;
    v   = va[12] ? e.v1   : e.v0;
    if (va[31:30] == KSEG01) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = (va[31:29] == KSEG1);
    end else if (!hit) begin
      r.refill = 1'b1;
    end else begin
      r.paddr    = {pfn, va[11:0]};
      r.inval    = ~v;
      r.mod      = v & store & ~d;
      r.uncached = (c == C_UNCACHED);
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational associative match of one VPN2/ASID against all TLB tags, lowest index wins.
// With TLB_MULTIHIT_EN defined it also flags more than one matching entry.
module tlb_match
  import tlb_unit_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  tlb_tag_t          tags_i [TLBNUM],
  input  logic [18:0]       vpn2_i,
  input  logic [7:0]        asid_i,
  output logic              hit_o,
  output logic [IDXW-1:0]   idx_o
`ifdef TLB_MULTIHIT_EN
  ,
  output logic              multi_hit_o
`endif
);

  logic [TLBNUM-1:0] match_s;

  // Per-entry match: VPN2 equal and either global or ASID equal.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match_s[i] = (tags_i[i].vpn2 == vpn2_i) && (tags_i[i].g || (tags_i[i].asid == asid_i));
    end
  end

  // Ascending scan keeps the first (lowest) hit; any later hit marks a multi-hit.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
`ifdef TLB_MULTIHIT_EN
    multi_hit_o = 1'b0;
`endif
    for (int i = 0; i < TLBNUM; i++) begin
      if (match_s[i] && !hit_o) begin
        hit_o = 1'b1;
        idx_o = IDXW'(i);
`ifdef TLB_MULTIHIT_EN
      end else if (match_s[i]) begin
        multi_hit_o = 1'b1;
`endif
      end else begin
        hit_o = hit_o;
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: tlbwi/tlbr/tlbp service for CP0 plus registered fetch and data translation.
// Optional TLB_MULTIHIT_EN adds the multi_hit output.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDXW-1:0]    tlb_index,
  input  logic               tlbwi_we,
  input  logic [ENTRY_W-1:0] tlbwi_entry,
  input  logic               tlbr_req,
  output logic               tlbr_wen,
  output logic [ENTRY_W-1:0] tlbr_entry,
  input  logic               tlbp_req,
  input  logic [31:0]        tlbp_entryhi,
  output logic               tlbp_wen,
  output logic [31:0]        tlbp_index,
  input  logic               i_en,
  input  logic [31:0]        i_vaddr,
  output logic [31:0]        i_paddr,
  output logic               i_refill,
  output logic               i_inval,
  output logic               i_uncached,
  input  logic               d_en,
  input  logic [31:0]        d_vaddr,
  input  logic               d_store,
  output logic [31:0]        d_paddr,
  output logic               d_refill,
  output logic               d_inval,
  output logic               d_mod,
  output logic               d_uncached
`ifdef TLB_MULTIHIT_EN
  ,
  output logic               multi_hit
`endif
);

  tlb_entry_t         entries_q [TLBNUM];
  tlb_tag_t           tags_s    [TLBNUM];
  logic               i_hit_s, d_hit_s, p_hit_s;
  logic [IDXW-1:0]    i_idx_s, d_idx_s, p_idx_s;
  xlate_t             i_res_d, i_res_q, d_res_d, d_res_q;
  logic [31:0]        tlbp_index_d, tlbp_index_q;
  logic [ENTRY_W-1:0] tlbr_entry_d, tlbr_entry_q;
  logic               tlbp_wen_q, tlbr_wen_q;
  logic               unused_entryhi_s;

  assign unused_entryhi_s = ^tlbp_entryhi[12:8];

  // Entry storage; a write lands at the edge so same-cycle users see the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        entries_q[i] <= '0;
      end
    end else if (tlbwi_we) begin
      entries_q[tlb_index] <= tlbwi_entry;
    end
  end

  // Tag view of each entry for the match units.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      tags_s[i] = '{vpn2: entries_q[i].vpn2, asid: entries_q[i].asid, g: entries_q[i].g};
    end
  end

`ifdef TLB_MULTIHIT_EN
  logic i_mh_s, d_mh_s, p_mh_s;
  logic i_mh_d, d_mh_d, p_mh_d, i_mh_q, d_mh_q, p_mh_q, multi_hit_q;
`endif

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_i (
    .tags_i      (tags_s),
    .vpn2_i      (i_vaddr[31:13]),
    .asid_i      (tlbp_entryhi[7:0]),
`ifdef TLB_MULTIHIT_EN
    .multi_hit_o (i_mh_s),
`endif
    .hit_o       (i_hit_s),
    .idx_o       (i_idx_s)
  );

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_d (
    .tags_i      (tags_s),
    .vpn2_i      (d_vaddr[31:13]),
    .asid_i      (tlbp_entryhi[7:0]),
`ifdef TLB_MULTIHIT_EN
    .multi_hit_o (d_mh_s),
`endif
    .hit_o       (d_hit_s),
    .idx_o       (d_idx_s)
  );

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_p (
    .tags_i      (tags_s),
    .vpn2_i      (tlbp_entryhi[31:13]),
    .asid_i      (tlbp_entryhi[7:0]),
`ifdef TLB_MULTIHIT_EN
    .multi_hit_o (p_mh_s),
`endif
    .hit_o       (p_hit_s),
    .idx_o       (p_idx_s)
  );

  // Next-state for translation results and CP0 responses; disabled ports hold.
  always_comb begin
    i_res_d      = i_res_q;
    d_res_d      = d_res_q;
    tlbp_index_d = tlbp_index_q;
    tlbr_entry_d = tlbr_entry_q;
    if (i_en) begin
      i_res_d = xlate(entries_q[i_idx_s], i_hit_s, i_vaddr, 1'b0);
    end else begin
      i_res_d = i_res_q;
    end
    if (d_en) begin
      d_res_d = xlate(entries_q[d_idx_s], d_hit_s, d_vaddr, d_store);
    end else begin
      d_res_d = d_res_q;
    end
    if (tlbp_req) begin
      tlbp_index_d = p_hit_s ? {1'b0, 31'(p_idx_s)} : 32'h8000_0000;
    end else begin
      tlbp_index_d = tlbp_index_q;
    end
    if (tlbr_req) begin
      tlbr_entry_d = entries_q[tlb_index];
    end else begin
      tlbr_entry_d = tlbr_entry_q;
    end
  end

  // Result registers; reset also cancels any pending CP0 pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_res_q      <= '0;
      d_res_q      <= '0;
      tlbp_index_q <= '0;
      tlbr_entry_q <= '0;
      tlbp_wen_q   <= 1'b0;
      tlbr_wen_q   <= 1'b0;
    end else begin
      i_res_q      <= i_res_d;
      d_res_q      <= d_res_d;
      tlbp_index_q <= tlbp_index_d;
      tlbr_entry_q <= tlbr_entry_d;
      tlbp_wen_q   <= tlbp_req;
      tlbr_wen_q   <= tlbr_req;
    end
  end

`ifdef TLB_MULTIHIT_EN
  // Multi-hit tracks each source alongside its own result; unmapped lookups never count.
  always_comb begin
    i_mh_d = i_en ? (i_mh_s && (i_vaddr[31:30] != KSEG01)) : i_mh_q;
    d_mh_d = d_en ? (d_mh_s && (d_vaddr[31:30] != KSEG01)) : d_mh_q;
    p_mh_d = tlbp_req ? p_mh_s : p_mh_q;
  end

  // Multi-hit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_mh_q      <= 1'b0;
      d_mh_q      <= 1'b0;
      p_mh_q      <= 1'b0;
      multi_hit_q <= 1'b0;
    end else begin
      i_mh_q      <= i_mh_d;
      d_mh_q      <= d_mh_d;
      p_mh_q      <= p_mh_d;
      multi_hit_q <= i_mh_d | d_mh_d | p_mh_d;
    end
  end

  assign multi_hit = multi_hit_q;
`endif

  assign i_paddr    = i_res_q.paddr;
  assign i_refill   = i_res_q.refill;
  assign i_inval    = i_res_q.inval;
  assign i_uncached = i_res_q.uncached;
  assign d_paddr    = d_res_q.paddr;
  assign d_refill   = d_res_q.refill;
  assign d_inval    = d_res_q.inval;
  assign d_mod      = d_res_q.mod;
  assign d_uncached = d_res_q.uncached;
  assign tlbp_index = tlbp_index_q;
  assign tlbp_wen   = tlbp_wen_q;
  assign tlbr_entry = tlbr_entry_q;
  assign tlbr_wen   = tlbr_wen_q;

endmodule

// File: tb/tb_tlb_unit.sv
// Directed self-checking bench for tlb_unit; optional multi_hit checked when TLB_MULTIHIT_EN is defined.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tlb_index;
  logic        tlbwi_we;
  logic [77:0] tlbwi_entry;
  logic        tlbr_req;
  logic        tlbr_wen;
  logic [77:0] tlbr_entry;
  logic        tlbp_req;
  logic [31:0] tlbp_entryhi;
  logic        tlbp_wen;
  logic [31:0] tlbp_index;
  logic        i_en, d_en, d_store;
  logic [31:0] i_vaddr, d_vaddr, i_paddr, d_paddr;
  logic        i_refill, i_inval, i_uncached;
  logic        d_refill, d_inval, d_mod, d_uncached;
`ifdef TLB_MULTIHIT_EN
  logic        multi_hit;
`endif

  int checks = 0;
  int errors = 0;

  logic [77:0] e3a, e3b, e3d, e3e, e1;

  always #5 clk = ~clk;

  tlb_unit dut (
    .clk          (clk),
    .rst          (rst),
    .tlb_index    (tlb_index),
    .tlbwi_we     (tlbwi_we),
    .tlbwi_entry  (tlbwi_entry),
    .tlbr_req     (tlbr_req),
    .tlbr_wen     (tlbr_wen),
    .tlbr_entry   (tlbr_entry),
    .tlbp_req     (tlbp_req),
    .tlbp_entryhi (tlbp_entryhi),
    .tlbp_wen     (tlbp_wen),
    .tlbp_index   (tlbp_index),
    .i_en         (i_en),
    .i_vaddr      (i_vaddr),
    .i_paddr      (i_paddr),
    .i_refill     (i_refill),
    .i_inval      (i_inval),
    .i_uncached   (i_uncached),
    .d_en         (d_en),
    .d_vaddr      (d_vaddr),
    .d_store      (d_store),
    .d_paddr      (d_paddr),
    .d_refill     (d_refill),
    .d_inval      (d_inval),
    .d_mod        (d_mod),
`ifdef TLB_MULTIHIT_EN
    .multi_hit    (multi_hit),
`endif
    .d_uncached   (d_uncached)
  );

  function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                     input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                                     input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    e3a = mk(19'h00040, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0ABCD, 3'd3, 1'b0, 1'b0);
    e3b = mk(19'h00040, 8'd5, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0ABCD, 3'd3, 1'b0, 1'b0);
    e3d = mk(19'h00040, 8'd5, 1'b1, 20'h12345, 3'd2, 1'b0, 1'b1, 20'h0ABCD, 3'd3, 1'b0, 1'b0);
    e3e = mk(19'h00040, 8'd5, 1'b1, 20'h77777, 3'd3, 1'b1, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
    e1  = mk(19'h00040, 8'd9, 1'b1, 20'h55555, 3'd3, 1'b1, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);

    rst = 1'b1; tlb_index = 4'd0; tlbwi_we = 1'b0; tlbwi_entry = 78'd0;
    tlbr_req = 1'b0; tlbp_req = 1'b0; tlbp_entryhi = 32'd0;
    i_en = 1'b0; d_en = 1'b0; d_store = 1'b0; i_vaddr = 32'd0; d_vaddr = 32'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_d", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, 80'd0);
    chk("reset_i", {45'd0, i_paddr, i_refill, i_inval, i_uncached}, 80'd0);
    chk("reset_cp0", {46'd0, tlbp_wen, tlbr_wen, tlbp_index}, 80'd0);

    // Basic hit on the even page of entry 3
    tlb_index = 4'd3; tlbwi_entry = e3a; tlbwi_we = 1'b1;
    tick();
    tlbwi_we = 1'b0;
    tlbp_entryhi = 32'h0008_0005; d_en = 1'b1; d_vaddr = 32'h0008_0ABC;
    tick();
    chk("d_hit_even", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h12345ABC, 4'b0000});

    d_en = 1'b0; d_vaddr = 32'h0008_1ABC;
    tick();
    chk("d_hold", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h12345ABC, 4'b0000});

    // ASID mismatch misses; a same-cycle rewrite is not yet visible
    tlbp_entryhi = 32'h0008_0006; d_en = 1'b1; d_vaddr = 32'h0008_0ABC;
    tick();
    chk("d_asid_miss", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h0, 4'b1000});
    tlbwi_entry = e3b; tlbwi_we = 1'b1;
    tick();
    tlbwi_we = 1'b0;
    chk("d_write_same_cycle_old", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h0, 4'b1000});
    tick();
    chk("d_global_hit", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h12345ABC, 4'b0000});

    // Odd page invalid outranks modify; then a clean even page with C=2
    d_vaddr = 32'h0008_1ABC; d_store = 1'b1;
    tick();
    chk("d_odd_inval", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h0ABCDABC, 4'b0100});
    tlbwi_entry = e3d; tlbwi_we = 1'b1;
    tick();
    tlbwi_we = 1'b0;
    d_vaddr = 32'h0008_0ABC;
    tick();
    chk("d_mod_uncached", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h12345ABC, 4'b0011});
    d_en = 1'b0; d_store = 1'b0;

    // Instruction port: kseg1, kseg0, mapped miss
    i_en = 1'b1; i_vaddr = 32'hBFC0_0000;
    tick();
    chk("i_kseg1", {45'd0, i_paddr, i_refill, i_inval, i_uncached}, {45'd0, 32'h1FC00000, 3'b001});
    i_vaddr = 32'h8000_1234;
    tick();
    chk("i_kseg0", {45'd0, i_paddr, i_refill, i_inval, i_uncached}, {45'd0, 32'h00001234, 3'b000});
    i_vaddr = 32'h0040_0000;
    tick();
    chk("i_miss", {45'd0, i_paddr, i_refill, i_inval, i_uncached}, {45'd0, 32'h0, 3'b100});
    i_en = 1'b0;

    // Probe miss, pulse width, probe hit
    tlbp_entryhi = 32'h0010_0005; tlbp_req = 1'b1;
    tick();
    tlbp_req = 1'b0;
    chk("tlbp_miss", {47'd0, tlbp_wen, tlbp_index}, {47'd1, 32'h80000000});
    tick();
    chk("tlbp_pulse_end", {79'd0, tlbp_wen}, 80'd0);
    tlbp_entryhi = 32'h0008_0006; tlbp_req = 1'b1;
    tick();
    tlbp_req = 1'b0;
    chk("tlbp_hit3", {47'd0, tlbp_wen, tlbp_index}, {47'd1, 32'h00000003});

    // Read racing a write returns the old entry; held request gives two pulses
    tlb_index = 4'd3; tlbwi_entry = e3e; tlbwi_we = 1'b1; tlbr_req = 1'b1;
    tick();
    tlbwi_we = 1'b0;
    chk("tlbr_old", {1'b0, tlbr_wen, tlbr_entry}, {2'b01, e3d});
    tick();
    tlbr_req = 1'b0;
    chk("tlbr_new", {1'b0, tlbr_wen, tlbr_entry}, {2'b01, e3e});
    tick();
    chk("tlbr_pulse_end", {79'd0, tlbr_wen}, 80'd0);

    // Lower index wins; probe and read in the same cycle
    tlb_index = 4'd1; tlbwi_entry = e1; tlbwi_we = 1'b1;
    tick();
    tlbwi_we = 1'b0;
    tlbp_entryhi = 32'h0008_0005; tlbp_req = 1'b1; tlbr_req = 1'b1;
    d_en = 1'b1; d_vaddr = 32'h0008_0ABC;
    tick();
    tlbp_req = 1'b0; tlbr_req = 1'b0; d_en = 1'b0;
    chk("both_pulses", {78'd0, tlbp_wen, tlbr_wen}, 80'd3);
    chk("tlbp_lowest", {48'd0, tlbp_index}, {48'd0, 32'h00000001});
    chk("tlbr_idx1", {2'b00, tlbr_entry}, {2'b00, e1});
    chk("d_lowest", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, {44'd0, 32'h55555ABC, 4'b0000});
`ifdef TLB_MULTIHIT_EN
    chk("multi_hit", {79'd0, multi_hit}, 80'd1);
`endif

    // Reset cancels pending pulses and clears entries
    rst = 1'b1; tlbp_req = 1'b1; tlbr_req = 1'b1; tlb_index = 4'd3;
    tick();
    rst = 1'b0; tlbp_req = 1'b0;
    chk("rst_cancel", {78'd0, tlbp_wen, tlbr_wen}, 80'd0);
    chk("rst_d_clear", {44'd0, d_paddr, d_refill, d_inval, d_mod, d_uncached}, 80'd0);
    tick();
    tlbr_req = 1'b0;
    chk("rst_entry_clear", {1'b0, tlbr_wen, tlbr_entry}, {2'b01, 78'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
